// File: rtl/ram_arb_pkg.sv
// Shared opcodes, FSM states and requester IDs for the RAM port arbiter.
package ram_arb_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    WAIT_RD
  } arb_state_t;

  typedef enum logic {
    REQ_SPI,
    REQ_HOST
  } req_id_t;

endpackage

// File: rtl/ram_arb_req_buf.sv
// One-entry command buffer; a load while full is dropped and flagged on ovf.
module ram_arb_req_buf
  import ram_arb_pkg::*;
#(
  parameter int CMD_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CMD_W-1:0] load_data,
  input  logic             free,
  output logic             full,
  output logic [CMD_W-1:0] data,
  output logic             ovf
);

  // free only happens while full and load only while empty, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (free) full <= 1'b0;
      if (load && !full) begin
        full <= 1'b1;
        data <= load_data;
      end
    end
  end

  assign ovf = load & full;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the command RAM between SPI and host, locking the grant over two-beat transactions.
// Define RAM_ARB_FIXED_PRIO_EN to make SPI win every IDLE tie instead of round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int LOCK_TIMEOUT = 16,
  parameter int TMR_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cmd_valid,
  input  logic [DATA_W+1:0] spi_cmd,
  output logic              spi_rd_valid,
  output logic [DATA_W-1:0] spi_rd_data,
  input  logic              host_cmd_valid,
  input  logic [DATA_W+1:0] host_cmd,
  output logic              host_cmd_ready,
  output logic              host_rd_valid,
  output logic [DATA_W-1:0] host_rd_data,
  output logic [DATA_W+1:0] ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic              spi_ovf_err,
  output logic              timeout_err
);

  localparam int CMD_W = DATA_W + 2;

  logic             spi_full, host_full;
  logic             spi_free, host_free;
  logic             spi_ovf, host_ovf_unused;
  logic [CMD_W-1:0] spi_data, host_data;
  logic             issue;
  logic [CMD_W-1:0] issue_cmd;
  logic [1:0]       issue_op;
  logic             timer_expired;

  arb_state_t       state;
  req_id_t          owner;
  logic [TMR_W-1:0] timer;
`ifndef RAM_ARB_FIXED_PRIO_EN
  req_id_t          last_grant;
`endif

  ram_arb_req_buf #(.CMD_W(CMD_W)) u_spi_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (spi_cmd_valid),
    .load_data (spi_cmd),
    .free      (spi_free),
    .full      (spi_full),
    .data      (spi_data),
    .ovf       (spi_ovf)
  );

  ram_arb_req_buf #(.CMD_W(CMD_W)) u_host_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (host_cmd_valid & host_cmd_ready),
    .load_data (host_cmd),
    .free      (host_free),
    .full      (host_full),
    .data      (host_data),
    .ovf       (host_ovf_unused)
  );

  assign host_cmd_ready = ~host_full;

  // Grant decision: freeing a buffer is the same thing as issuing its command this cycle
  always_comb begin
    spi_free  = 1'b0;
    host_free = 1'b0;
    case (state)
      IDLE: begin
        if (spi_full && host_full) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          spi_free = 1'b1;
`else
          if (last_grant == REQ_HOST) spi_free = 1'b1;
          else                        host_free = 1'b1;
`endif
        end else begin
          spi_free  = spi_full;
          host_free = host_full;
        end
      end
      LOCKED: begin
        spi_free  = (owner == REQ_SPI)  && spi_full;
        host_free = (owner == REQ_HOST) && host_full;
      end
      default: ;
    endcase
  end

  assign issue         = spi_free | host_free;
  assign issue_cmd     = spi_free ? spi_data : host_data;
  assign issue_op      = issue_cmd[CMD_W-1 -: 2];
  assign timer_expired = (timer == TMR_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= REQ_SPI;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant    <= REQ_HOST;
`endif
      timer         <= '0;
      ram_din       <= '0;
      ram_rx_valid  <= 1'b0;
      timeout_err   <= 1'b0;
      spi_rd_valid  <= 1'b0;
      host_rd_valid <= 1'b0;
      spi_rd_data   <= '0;
      host_rd_data  <= '0;
      spi_ovf_err   <= 1'b0;
    end else begin
      ram_rx_valid  <= issue;
      timeout_err   <= 1'b0;
      spi_rd_valid  <= 1'b0;
      host_rd_valid <= 1'b0;
      if (spi_ovf) spi_ovf_err <= 1'b1;
      if (issue)   ram_din     <= issue_cmd;

      case (state)
        IDLE: begin
          timer <= '0;
          if (issue) begin
            owner <= spi_free ? REQ_SPI : REQ_HOST;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant <= spi_free ? REQ_SPI : REQ_HOST;
`endif
            case (issue_op)
              OP_WR_ADDR, OP_RD_ADDR: state <= LOCKED;
              OP_RD_DATA:             state <= WAIT_RD;
              default:                state <= IDLE;
            endcase
          end
        end
        LOCKED: begin
          if (issue) begin
            timer <= '0;
            case (issue_op)
              OP_WR_DATA: state <= IDLE;
              OP_RD_DATA: state <= WAIT_RD;
              default:    state <= LOCKED;
            endcase
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_RD: begin
          if (ram_tx_valid) begin
            if (owner == REQ_SPI) begin
              spi_rd_valid <= 1'b1;
              spi_rd_data  <= ram_dout;
            end else begin
              host_rd_valid <= 1'b1;
              host_rd_data  <= ram_dout;
            end
            timer <= '0;
            state <= IDLE;
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 256x8 RAM (10-bit {op,data} command interface) between two requesters: the SPI slave command stream and a local host port.
- Sits between SPI slave / host and the RAM. Buffers each requester's commands and arbitrates round-robin.
- Locks the grant across a two-beat transaction (address, then data or read), so the two requesters' address and data beats never interleave.
- Routes RAM read data back to the requester that issued the read.

Parameters:
- DATA_W, 8, RAM data width; command width is DATA_W+2.
- LOCK_TIMEOUT, 16, max cycles in LOCKED or WAIT_RD before forced release (>=2).
- TMR_W, 5, timeout counter width; must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- spi_cmd_valid  in  1  one-cycle pulse: spi_cmd valid.
- spi_cmd  in  DATA_W+2  {op[1:0], data}.
- spi_rd_valid  out  1  one-cycle pulse: spi_rd_data valid.
- spi_rd_data  out  DATA_W  read data for SPI.
- host_cmd_valid  in  1  host command valid; accepted when host_cmd_ready=1.
- host_cmd  in  DATA_W+2  {op[1:0], data}.
- host_cmd_ready  out  1  host buffer empty.
- host_rd_valid  out  1  one-cycle pulse: host_rd_data valid.
- host_rd_data  out  DATA_W  read data for host.
- ram_din  out  DATA_W+2  command to RAM.
- ram_rx_valid  out  1  one-cycle command strobe to RAM.
- ram_dout  in  DATA_W  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.
- spi_ovf_err  out  1  sticky: SPI command dropped.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset:
  - All outputs go to 0 and host_cmd_ready goes to 1.
  - FSM goes to IDLE; last_grant is set to HOST, so SPI wins the first tie.
  - Both buffers are cleared, the timer is 0, and spi_ovf_err is cleared.
  - Reset mid-transaction discards the pending command and the lock, with no RAM strobe. Any partial RAM address latch is the requester's problem.
- Opcodes:
  - 00 = write address, 10 = read address: first beats.
  - 01 = write data, 11 = read trigger: second beats.
- Buffers: each requester has a 1-entry buffer, loaded on valid (host only when ready).
  - SPI valid while its buffer is full: the command is dropped and spi_ovf_err is set.
  - A buffer is freed in the cycle the FSM issues its command.
- Issue: a registered single-cycle ram_rx_valid pulse with ram_din equal to the buffered command.
  - Latency: cmd_valid at cycle N gives ram_rx_valid at N+2 when uncontended.
- IDLE state:
  - Pick a requester with a full buffer; if both are full, pick the one not equal to last_grant. Set owner and last_grant.
  - Issue the command, then branch on its op:
    - op 00 or 10: go to LOCKED.
    - op 11: go to WAIT_RD.
    - op 01 (orphan write data, legal reuse of the RAM address latch): stay in IDLE.
- LOCKED state: only the owner's buffer is served; the timer increments every cycle.
  - Owner op 01: issue, go to IDLE.
  - Owner op 11: issue, go to WAIT_RD.
  - Owner op 00 or 10: issue, stay in LOCKED, reset the timer (restart).
  - Timer reaches LOCK_TIMEOUT: pulse timeout_err, go to IDLE with no issue.
- WAIT_RD state:
  - ram_tx_valid: register ram_dout to the owner's rd_data and pulse the owner's rd_valid the next cycle; go to IDLE.
  - Timeout behaves as in LOCKED.
  - ram_tx_valid outside WAIT_RD is ignored.
- The timer clears on every state entry.
- The non-owner's buffer holds while locked. SPI commands arriving then are preserved up to 1 deep; a further command overflows.
- A buffer loaded in the same cycle it is issued from is not possible: load and free never coincide, because a full buffer cannot load.
- rd_data holds its value between pulses.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: the IDLE tie-break always picks SPI; last_grant is unused.
- Undefined: round-robin as above.
- Lock, timeout and routing are identical in both cases.

Decomposition:
- Package ram_arb_pkg:
  - Opcode localparams OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA.
  - State enum IDLE, LOCKED, WAIT_RD.
  - Requester ID type REQ_SPI, REQ_HOST.
- Sub-module ram_arb_req_buf: a 1-entry command buffer with valid, data, free strobe and overflow output, instantiated twice.

Test Plan:
- SPI write 0x000→addr 0 then 0x1A5 (op 01, data A5), no host traffic: two ram_rx_valid pulses with din 0x000 then 0x1A5; FSM ends in IDLE.
- SPI read: 0x205, then 0x300, with ram_tx_valid/ram_dout=0x3C driven 2 cycles after the second strobe → spi_rd_valid pulse with 0x3C; host_rd_valid stays 0.
- Both requesters load 0x000/0x010 in the same cycle after reset → SPI granted first. Host's 0x010 is not issued until SPI's 0x1xx completes, then the host is granted. RAM sees SPI addr, SPI data, host addr, host data, in that order.
- SPI sends addr 0x007 and nothing else → after LOCK_TIMEOUT=16 cycles timeout_err pulses once; a waiting host command is issued the next IDLE cycle.
- Three SPI pulses on consecutive cycles while the host holds the lock → the first is buffered; the next overflows and spi_ovf_err=1 until rst.
- Assert rst in WAIT_RD → all outputs go to 0 immediately; a late ram_tx_valid produces no rd_valid.
